chan_select_scan: RTL and testbench

- Parametrised, registered N-to-1 channel selector; the next-generation successor to the fixed 8:1 single-bit selectors in the ALU datapath.
- Selects one WIDTH-bit channel of NCH, either directly by `sel` or by an internal auto-scan pointer.
- Result goes to a single output register with a valid/ready handshake.
- Sits between ALU result sources and the downstream result/display stage.

---
 rtl/chan_select_pkg.sv | 18 +
 rtl/chan_select_scan_mux_n1.sv | 22 ++
 rtl/chan_select_scan.sv | 160 ++++++++++++++++
 tb/tb_chan_select_scan.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_select_pkg.sv
// Shared types, defaults and helpers for the chan_select_scan channel selector.
package chan_select_pkg;

  // Capture source: the direct sel index, or the internal scan pointer.
  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_NCH   = 8;

  // Circular increment over 0..nch-1.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned nch);
    return (idx + 1 >= nch) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/chan_select_scan_mux_n1.sv
// mux_n1: purely combinational WIDTH-bit NCH:1 selector.
// Channel k lives at din[k*WIDTH +: WIDTH]; an index beyond NCH-1 yields zero.
module mux_n1 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 8,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      idx,
  output logic [WIDTH-1:0]     dout
);

  // Pick the addressed channel.
  always_comb begin
    // NOTE: default assignment first so every path drives dout and no latch is inferred.
    dout = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (idx == SELW'(k)) dout = din[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/chan_select_scan.sv
// chan_select_scan: registered N-to-1 channel selector with valid/ready output.
// Captures one channel per load, chosen either directly by sel (mode=0) or by
// an internal round-robin scan pointer (mode=1).
// Optional build macro CHAN_MASK_EN adds the ch_mask input: masked channels are
// skipped by the scan and rejected (sel_err) in direct mode.
module chan_select_scan
  import chan_select_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NCH   = DEF_NCH,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 en,
  input  logic                 out_ready,
`ifdef CHAN_MASK_EN
  input  logic [NCH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  output logic                 scan_wrap,
  output logic                 sel_err
);

  mode_e            mode_s;
  logic [NCH-1:0]   ch_en;

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  chan_q, chan_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic             any_en, up_hit, scan_hit, sel_ok;
  logic [SELW-1:0]  first_any, first_up, top_idx, scan_idx, mux_idx;
  logic [WIDTH-1:0] mux_out;
  logic             slot_free, load;

  assign mode_s = mode_e'(mode);

`ifdef CHAN_MASK_EN
  assign ch_en = ch_mask;
`else
  assign ch_en = '1;
`endif

  // Locate the scan target (first enabled channel at or after ptr, wrapping)
  // and the highest enabled channel, which marks the end of a scan round.
  always_comb begin
    any_en    = 1'b0;
    up_hit    = 1'b0;
    first_any = '0;
    first_up  = '0;
    top_idx   = '0;
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if (ch_en[k]) begin
        if (!any_en) top_idx = SELW'(k);
        any_en    = 1'b1;
        first_any = SELW'(k);
        if (SELW'(k) >= ptr_q) begin
          up_hit   = 1'b1;
          first_up = SELW'(k);
        end
      end
    end
    scan_hit = any_en;
    scan_idx = up_hit ? first_up : first_any;
  end

  // Direct-mode index is usable only if in range and enabled.
  always_comb begin
    sel_ok = 1'b0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (sel == SELW'(k) && ch_en[k]) sel_ok = 1'b1;
    end
  end

  assign mux_idx = (mode_s == MODE_SCAN) ? scan_idx : sel;

  mux_n1 #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .SELW  (SELW)
  ) u_mux (
    .din  (din),
    .idx  (mux_idx),
    .dout (mux_out)
  );

  assign slot_free = !valid_q || out_ready;
  assign load      = en && slot_free;

  // Next-state: capture on load, drain on accept, hold while stalled.
  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;

    // An accepted sample leaves the slot unless a new one replaces it below.
    if (valid_q && out_ready) valid_d = 1'b0;

    if (load) begin
      if (mode_s == MODE_SCAN) begin
        if (scan_hit) begin
          data_d  = mux_out;
          chan_d  = scan_idx;
          valid_d = 1'b1;
          ptr_d   = SELW'(next_idx(32'(scan_idx), NCH));
          wrap_d  = (scan_idx == top_idx);
        end
      end else if (sel_ok) begin
        data_d  = mux_out;
        chan_d  = sel;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
    end

    // Every scan starts from channel 0 after time spent in direct mode.
    if (mode_s == MODE_DIRECT) ptr_d = '0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;
  assign scan_wrap = wrap_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_chan_select_scan.sv
// Self-checking bench for chan_select_scan: an 8-channel and a 6-channel
// instance, directed scenarios followed by randomized traffic, all compared
// against a behavioural model of the selector.
module tb_chan_select_scan;

  localparam int W  = 8;
  localparam int NA = 8;
  localparam int SA = 3;
  localparam int NB = 6;
  localparam int SB = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic [NA*W-1:0] din_a;
  logic [SA-1:0]   sel_a;
  logic            mode_a, en_a, rdy_a;
  logic [NA-1:0]   mask_a;
  logic [W-1:0]    a_data;
  logic [SA-1:0]   a_chan;
  logic            a_valid, a_wrap, a_err;

  logic [NB*W-1:0] din_b;
  logic [SB-1:0]   sel_b;
  logic            mode_b, en_b, rdy_b;
  logic [NB-1:0]   mask_b;
  logic [W-1:0]    b_data;
  logic [SB-1:0]   b_chan;
  logic            b_valid, b_wrap, b_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    int         chan;
    int         ptr;
    logic       wrap;
    logic       err;
  } mstate_t;

  mstate_t ea, eb;

  always #5 clk = ~clk;

  chan_select_scan #(.WIDTH(W), .NCH(NA)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din_a),
    .sel       (sel_a),
    .mode      (mode_a),
    .en        (en_a),
    .out_ready (rdy_a),
`ifdef CHAN_MASK_EN
    .ch_mask   (mask_a),
`endif
    .out_data  (a_data),
    .out_chan  (a_chan),
    .out_valid (a_valid),
    .scan_wrap (a_wrap),
    .sel_err   (a_err)
  );

  chan_select_scan #(.WIDTH(W), .NCH(NB)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din_b),
    .sel       (sel_b),
    .mode      (mode_b),
    .en        (en_b),
    .out_ready (rdy_b),
`ifdef CHAN_MASK_EN
    .ch_mask   (mask_b),
`endif
    .out_data  (b_data),
    .out_chan  (b_chan),
    .out_valid (b_valid),
    .scan_wrap (b_wrap),
    .sel_err   (b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of the selector described behaviourally: who is captured,
  // where the scan goes next, and which flags pulse.
  function automatic mstate_t model_step(input mstate_t s, input int nch,
                                         input logic [511:0] dinp, input int sel,
                                         input logic mode, input logic en,
                                         input logic rdy, input logic [63:0] mask,
                                         input logic rst_v);
    mstate_t n;
    int cap;
    int top;
    n      = s;
    n.wrap = 1'b0;
    n.err  = 1'b0;
    if (!rst_v) begin
      n = '{default: 0};
      return n;
    end
    top = -1;
    for (int k = 0; k < nch; k++) if (mask[k]) top = k;
    if (s.valid && rdy) n.valid = 1'b0;
    if (en && (!s.valid || rdy)) begin
      if (mode) begin
        cap = -1;
        for (int o = 0; o < nch; o++)
          if (cap < 0 && mask[(s.ptr + o) % nch]) cap = (s.ptr + o) % nch;
        if (cap >= 0) begin
          n.valid = 1'b1;
          n.data  = dinp[cap*8 +: 8];
          n.chan  = cap;
          n.ptr   = (cap + 1) % nch;
          n.wrap  = (cap == top);
        end
      end else if (sel < nch && mask[sel]) begin
        n.valid = 1'b1;
        n.data  = dinp[sel*8 +: 8];
        n.chan  = sel;
      end else begin
        n.valid = 1'b0;
        n.err   = 1'b1;
      end
    end
    if (!mode) n.ptr = 0;
    return n;
  endfunction

  // Advance one clock: model both instances at the edge, compare at the next negedge.
  task automatic step();
    @(posedge clk);
    ea = model_step(ea, NA, 512'(din_a), int'(sel_a), mode_a, en_a, rdy_a, 64'(mask_a), rst_n);
    eb = model_step(eb, NB, 512'(din_b), int'(sel_b), mode_b, en_b, rdy_b, 64'(mask_b), rst_n);
    @(negedge clk);
    check("a_data",  32'(a_data),  32'(ea.data));
    check("a_chan",  32'(a_chan),  32'(ea.chan));
    check("a_valid", 32'(a_valid), 32'(ea.valid));
    check("a_wrap",  32'(a_wrap),  32'(ea.wrap));
    check("a_err",   32'(a_err),   32'(ea.err));
    check("b_data",  32'(b_data),  32'(eb.data));
    check("b_chan",  32'(b_chan),  32'(eb.chan));
    check("b_valid", 32'(b_valid), 32'(eb.valid));
    check("b_wrap",  32'(b_wrap),  32'(eb.wrap));
    check("b_err",   32'(b_err),   32'(eb.err));
  endtask

  task automatic load_ramp();
    for (int k = 0; k < NA; k++) din_a[k*W +: W] = 8'(8'h10 + k);
    for (int k = 0; k < NB; k++) din_b[k*W +: W] = 8'(8'h20 + k);
  endtask

  initial begin
    bit found;
    ea = '{default: 0};
    eb = '{default: 0};
    rst_n  = 1'b0;
    load_ramp();
    sel_a  = 3'd5; mode_a = 1'b0; en_a = 1'b1; rdy_a = 1'b1; mask_a = '1;
    sel_b  = 3'd0; mode_b = 1'b0; en_b = 1'b0; rdy_b = 1'b1; mask_b = '1;

    // Reset held two cycles with en and out_ready high.
    step();
    step();
    check("rst_valid", 32'(a_valid), 32'(0));
    check("rst_data",  32'(a_data),  32'(0));
    check("rst_chan",  32'(a_chan),  32'(0));

    // First direct capture right after release.
    rst_n = 1'b1;
    step();
    check("direct5_data",  32'(a_data),  32'h15);
    check("direct5_chan",  32'(a_chan),  32'd5);
    check("direct5_valid", 32'(a_valid), 32'd1);

    // Back-to-back direct sweep.
    for (int s = 0; s < NA; s++) begin
      sel_a = SA'(s);
      step();
      check("sweep_data",  32'(a_data),  32'(8'h10 + s));
      check("sweep_valid", 32'(a_valid), 32'd1);
    end

    // Scan ten cycles: 0..7,0,1 with wrap on 7.
    mode_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("scan_chan", 32'(a_chan), 32'(i % NA));
      check("scan_wrap", 32'(a_wrap), 32'((i % NA) == NA - 1));
    end

    // Stall while channel 3 is held; inputs wiggle but must be ignored.
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      step();
      if (ea.valid && ea.chan == 3) found = 1'b1;
    end
    check("stall_reached", 32'(found), 32'd1);
    rdy_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_a = {$urandom(), $urandom()};
      sel_a = SA'($urandom_range(0, 7));
      step();
      check("stall_data", 32'(a_data), 32'h13);
      check("stall_chan", 32'(a_chan), 32'd3);
    end
    load_ramp();
    rdy_a = 1'b1;
    step();
    check("after_stall_chan", 32'(a_chan), 32'd4);
    check("after_stall_data", 32'(a_data), 32'h14);

    // Out-of-range sel on the 6-channel instance.
    mode_b = 1'b0; sel_b = 3'd7; en_b = 1'b1;
    step();
    check("bad_sel_err",   32'(b_err),   32'd1);
    check("bad_sel_valid", 32'(b_valid), 32'd0);
    en_b = 1'b0;
    step();
    check("bad_sel_pulse", 32'(b_err), 32'd0);

`ifdef CHAN_MASK_EN
    // Masked scan: enabled channels 0,2,5,7.
    begin
      int exp_seq[5] = '{0, 2, 5, 7, 0};
      mode_a = 1'b0;
      step();
      mask_a = 8'b1010_0101;
      mode_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
        step();
        check("mask_chan", 32'(a_chan), 32'(exp_seq[i]));
        check("mask_wrap", 32'(a_wrap), 32'(exp_seq[i] == 7));
      end
      mask_a = '0;
      for (int i = 0; i < 3; i++) begin
        step();
        check("mask_zero_valid", 32'(a_valid), 32'd0);
      end
      mask_a = '1;
    end
`endif

    // Randomized traffic on both instances, with occasional mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      din_a = {$urandom(), $urandom()};
      din_b = 48'({$urandom(), $urandom()});
      sel_a = SA'($urandom_range(0, 7));
      sel_b = SB'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) mode_a = ~mode_a;
      if ($urandom_range(0, 9) == 0) mode_b = ~mode_b;
      en_a  = ($urandom_range(0, 4) != 0);
      en_b  = ($urandom_range(0, 4) != 0);
      rdy_a = ($urandom_range(0, 9) < 7);
      rdy_b = ($urandom_range(0, 9) < 7);
`ifdef CHAN_MASK_EN
      if ($urandom_range(0, 19) == 0) begin
        mask_a = ($urandom_range(0, 7) == 0) ? '0 : NA'($urandom());
        mask_b = ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom());
      end
`endif
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
